// File: rtl/snake_step_sequencer.sv
// Move-tick pacing and direction latching for the snake game. Each tick issues
// one step request to the body datapath; a reported hit is held on `died`.
module snake_step_sequencer #(
  parameter int TICK_DIV = 2500000,
  parameter int TICK_W   = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_code,
  input  logic       init_snake,
  input  logic       screen_black,
  input  logic       screen_pause,
  output logic       step_req,
  output logic [1:0] step_dir,
  input  logic       step_ack,
  input  logic       hit,
  output logic       died,
  output logic [1:0] dir,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [1:0]        state;
  logic [TICK_W-1:0] cnt;
  logic [1:0]        pending;
  logic              run_en;
  logic              key_arrow;
  logic [1:0]        key_dir;
  logic              key_ok;

  assign run_en = !screen_black && !screen_pause;
  assign busy   = (state == S_STEP);

  always_comb begin
    key_arrow = 1'b1;
    key_dir   = 2'd0;
    case (key_code)
      8'h75:   key_dir = 2'd0;
      8'h74:   key_dir = 2'd1;
      8'h72:   key_dir = 2'd2;
      8'h6B:   key_dir = 2'd3;
      default: key_arrow = 1'b0;
    endcase
  end

  // Reversal is judged against the committed direction, so a chain of turns
  // inside one tick period only has to avoid reversing the current motion.
  assign key_ok = key_arrow && (state != S_IDLE) && ((key_dir ^ dir) != 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pending  <= 2'd1;
      dir      <= 2'd1;
      step_req <= 1'b0;
      step_dir <= 2'd1;
      died     <= 1'b0;
    end else if (init_snake) begin
      // Restart wins over everything, including a same-cycle ack.
      state    <= S_RUN;
      cnt      <= '0;
      pending  <= 2'd1;
      dir      <= 2'd1;
      step_req <= 1'b0;
      died     <= 1'b0;
    end else begin
      if (key_ok)
        pending <= key_dir;
      case (state)
        S_IDLE: cnt <= '0;
        S_RUN: begin
          if (screen_black) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (run_en) begin
            if (cnt == TICK_LAST) begin
              cnt      <= '0;
              step_req <= 1'b1;
              step_dir <= pending;
              dir      <= pending;
              state    <= S_STEP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_STEP: begin
          // Counter sits at 0 here, so the next period starts when STEP ends.
          if (step_ack) begin
            step_req <= 1'b0;
            if (hit) begin
              died  <= 1'b1;
              state <= S_DEAD;
            end else if (screen_black) begin
              state <= S_IDLE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        default: begin
          cnt <= '0;
          if (screen_black) begin
            died  <= 1'b0;
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Directed bench for snake_step_sequencer: stimulus queues expected step
// requests / death events, a negedge monitor pops and compares them.
module tb_snake_step_sequencer;
  localparam int TICK_DIV = 4;
  localparam int TICK_W   = 4;
  localparam int EV_REQ   = 0;
  localparam int EV_DIED  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key_code;
  logic       init_snake, screen_black, screen_pause;
  logic       step_req, step_ack, hit, died, busy;
  logic [1:0] step_dir, dir;

  typedef struct {int kind; int val; int cyc;} ev_t;
  ev_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic req_q = 1'b0;
  logic died_q = 1'b0;

  snake_step_sequencer #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .init_snake(init_snake),
    .screen_black(screen_black), .screen_pause(screen_pause),
    .step_req(step_req), .step_dir(step_dir), .step_ack(step_ack), .hit(hit),
    .died(died), .dir(dir), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind; e.val = val; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check_ev(input int kind, input int val);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d val %0d at cycle %0d expected none", kind, val, cyc);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_val", val, e.val);
      chk("ev_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: rising step_req / died are the observable responses.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (step_req && !req_q) check_ev(EV_REQ, int'(step_dir));
      if (died && !died_q)    check_ev(EV_DIED, 1);
    end
    req_q  = step_req;
    died_q = died;
  end

  task automatic wait_req();
    int n = 0;
    while (step_req !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (step_req !== 1'b1) chk("req_timeout", step_req, 1);
  endtask

  task automatic do_ack(input logic h, output int a);
    wait_req();
    @(negedge clk);
    step_ack = 1'b1; hit = h;
    @(negedge clk);
    step_ack = 1'b0; hit = 1'b0;
    a = cyc;
  endtask

  task automatic do_init(output int e);
    @(negedge clk);
    init_snake = 1'b1;
    @(negedge clk);
    init_snake = 1'b0;
    e = cyc;
  endtask

  task automatic key(input logic [7:0] k);
    key_code = k;
    @(negedge clk);
    key_code = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a, e0;
    rst_n = 1'b1; key_code = 8'h00; init_snake = 1'b0; screen_black = 1'b0;
    screen_pause = 1'b0; step_ack = 1'b0; hit = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_step_req", step_req, 0);
    chk("rst_step_dir", step_dir, 1);
    chk("rst_dir", dir, 1);
    chk("rst_died", died, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    key(8'h75);
    repeat (5) @(negedge clk);

    // Regular pacing: tick after 4 cycles, period 4 + 2-cycle ack latency
    do_init(e0);
    push(EV_REQ, 1, e0 + 4);
    wait_req();
    chk("busy_in_step", busy, 1);
    do_ack(1'b0, a);
    chk("busy_after_ack", busy, 0);
    push(EV_REQ, 1, a + 4);
    do_ack(1'b0, a);

    // Left is a reversal of right
    push(EV_REQ, 1, a + 4);
    key(8'h6B);
    do_ack(1'b0, a);
    // Up then left in one period: left still judged against committed right
    push(EV_REQ, 0, a + 4);
    key(8'h75); key(8'h6B);
    do_ack(1'b0, a);
    chk("dir_up", dir, 0);
    // Now moving up, left is legal; non-arrow code ignored
    push(EV_REQ, 3, a + 4);
    key(8'h1C); key(8'h6B);
    do_ack(1'b0, a);
    push(EV_REQ, 3, a + 4);
    key(8'h74); key(8'h1C);
    do_ack(1'b0, a);

    // Pause 20 cycles after two counts: request delayed by exactly 20
    push(EV_REQ, 3, a + 24);
    repeat (2) @(negedge clk);
    screen_pause = 1'b1;
    repeat (20) @(negedge clk);
    screen_pause = 1'b0;
    do_ack(1'b0, a);

    // Collision
    push(EV_REQ, 3, a + 4);
    push(EV_DIED, 1, a + 6);
    do_ack(1'b1, a);
    chk("died_set", died, 1);
    repeat (12) @(negedge clk);
    chk("died_hold", died, 1);
    chk("dead_no_req", step_req, 0);
    do_init(e0);
    chk("died_cleared", died, 0);
    chk("dir_reinit", dir, 1);

    // Black screen during request: handshake completes, then idle
    push(EV_REQ, 1, e0 + 4);
    wait_req();
    screen_black = 1'b1;
    do_ack(1'b0, a);
    chk("black_req_dropped", step_req, 0);
    repeat (3) @(negedge clk);
    screen_black = 1'b0;
    repeat (12) @(negedge clk);
    chk("idle_no_req", step_req, 0);

    // Async reset mid-request
    do_init(e0);
    push(EV_REQ, 1, e0 + 4);
    wait_req();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", step_req, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // up, left, down in one period from right ends as down
    do_init(e0);
    push(EV_REQ, 2, e0 + 4);
    key(8'h75); key(8'h6B); key(8'h72);
    wait_req();
    // init concurrent with a hit ack: init wins
    @(negedge clk);
    init_snake = 1'b1; step_ack = 1'b1; hit = 1'b1;
    @(negedge clk);
    init_snake = 1'b0; step_ack = 1'b0; hit = 1'b0;
    e0 = cyc;
    chk("init_ack_died", died, 0);
    chk("init_ack_req", step_req, 0);
    chk("init_ack_busy", busy, 0);
    chk("init_ack_dir", dir, 1);
    push(EV_REQ, 1, e0 + 4);
    do_ack(1'b0, a);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
